uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_W, default 7, data bits per frame; legal range 5..9.
REQ-002 Parameter CLK_DIV, default 5208, clk cycles per bit; legal range >= 2.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Port clk  in  1  single system clock; all state on rising edge.
REQ-006 Port rst  in  1  asynchronous, active-high reset.
REQ-007 Port mode  in  1  1 = single-shot, 0 = continuous.
REQ-008 Port en_start  in  1  start request, level input (button-like).
REQ-009 Port din  in  DATA_W  frame payload.
REQ-010 Port txd  out  1  serial line, idle high.
REQ-011 Port busy  out  1  high while a frame is in progress.
REQ-012 Port frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

Function
REQ-013 Frame order SHALL be: start (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-014 Each bit SHALL last exactly CLK_DIV clk cycles; the baud counter runs 0..CLK_DIV-1, resets to 0 at each frame start, and generates bit_tick at CLK_DIV-1.
REQ-015 The FSM SHALL use the states IDLE, START, DATA, PAR, STOP; PAR is skipped when PARITY=0.
REQ-016 Transitions: IDLE->START on trigger; START->DATA on bit_tick; DATA->PAR/STOP after bit DATA_W-1; PAR->STOP on bit_tick; STOP->IDLE or START after the last stop bit.
REQ-017 Single-shot trigger: en_start sampled high at edge N and low at edge N-1, while in IDLE with mode=1; txd SHALL go 0 from edge N+1.
REQ-018 Continuous trigger: in IDLE with mode=0, START SHALL be entered on the next edge without en_start.
REQ-019 din SHALL be latched into a shift register on entry to START; din changes during a frame SHALL NOT affect it.
REQ-020 Parity SHALL be computed on the latched data: odd gives an odd count of ones across data+parity; even gives an even count.
REQ-021 At the end of STOP, if mode=0, the FSM SHALL go directly to START (no idle gap) and relatch din; otherwise it SHALL go to IDLE.
REQ-022 mode SHALL be sampled only in IDLE and at the end of STOP; a mode change mid-frame SHALL NOT truncate the frame.
REQ-023 en_start edges arriving while busy=1 SHALL be ignored, not queued; holding en_start high SHALL yield exactly one frame.
REQ-024 busy SHALL be 1 in START/DATA/PAR/STOP and 0 in IDLE.
REQ-025 frame_done SHALL pulse in the same cycle as the final stop-bit bit_tick.
REQ-026 txd SHALL be registered, with no combinational glitches.

Reset
REQ-027 While rst=1: state=IDLE, txd=1, busy=0, frame_done=0, baud counter=0, bit index=0, shift register=0, en_start history=0.
REQ-028 Reset asserted mid-frame SHALL force txd=1 asynchronously and abort the frame, with no frame_done.
REQ-029 After rst deasserts, en_start already held high SHALL NOT trigger until it is seen low, then high.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum and the PARITY constants (PAR_NONE, PAR_ODD, PAR_EVEN).
REQ-031 The baud counter SHALL be the sub-module uart_baud_gen (params CLK_DIV; ports clk, rst, clear, bit_tick).
REQ-032 The RTL SHALL be 120-400 lines in total.

Verification
REQ-033 The bench SHALL run with CLK_DIV=4 and cover the following directed cases.
REQ-034 DATA_W=7, PARITY=0, STOP=1, mode=1, din=7'b1010101, en_start pulse -> txd bits 0,1,0,1,0,1,0,1,1, each 4 cycles; busy for 36 cycles; one frame_done.
REQ-035 DATA_W=8, PARITY=2, din=8'h55 -> parity bit 0; PARITY=1 with the same din -> parity bit 1.
REQ-036 mode=1, en_start held high for 1000 cycles -> exactly one frame and one frame_done.
REQ-037 mode=0, DATA_W=7, PARITY=0, din=7'b0101010 -> back-to-back 36-cycle frames with no idle cycle between stop and start; frame_done every 36 cycles; din changed mid-frame takes effect in the next frame only.
REQ-038 STOP_BITS=2 with rst pulsed at cycle 15 of a frame -> txd=1 during rst; busy=0; no frame_done; after release, no frame until a fresh en_start rising edge (mode=1).
REQ-039 mode switched 0->1 mid-frame -> the current frame completes fully, then the FSM goes to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter:
//   - state_t    : transmitter FSM states
//   - PAR_*      : parity mode encodings for the PARITY parameter
//   - parity_bit : parity bit for a data word under a given parity mode
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   // Widest supported data word; narrower words are zero-extended.
   localparam int unsigned MAX_DATA_W = 9;

   // Bit that makes the total count of ones odd (PAR_ODD) or even (PAR_EVEN).
   function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                       input int unsigned           mode);
      return (^data) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..CLK_DIV-1 and raises bit_tick for exactly the
// cycle in which the count equals CLK_DIV-1.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   clear    in  synchronous restart: count returns to 0 on the next edge
//   bit_tick out high during the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int unsigned CLK_DIV = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick
);

   localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   // bit_tick is registered one count early so it lines up with cnt == CLK_DIV-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         bit_tick <= 1'b0;
      end else if (clear) begin
         cnt      <= '0;
         bit_tick <= 1'b0;
      end else begin
         if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         bit_tick <= (cnt == CNT_W'(CLK_DIV - 2));
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Configurable UART transmitter: start bit, DATA_W data bits LSB first,
// optional parity bit, STOP_BITS stop bits. Single-shot frames are launched by
// a rising edge of en_start; continuous mode streams back-to-back frames.
// Ports:
//   clk        in   system clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   mode       in   1 = single-shot, 0 = continuous
//   en_start   in   level start request (rising edge triggers in single-shot)
//   din        in   frame payload, latched at frame start
//   txd        out  serial line, idle high (registered)
//   busy       out  high while a frame is in progress (registered)
//   frame_done out  one-cycle pulse in the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W    = 7,
   parameter int unsigned CLK_DIV   = 5208,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic              en_start,
   input  logic [DATA_W-1:0] din,
   output logic              txd,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned IDX_W = $clog2(DATA_W);

   state_t            state;
   state_t            state_n;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_n;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_n;
   logic              par_q;
   logic              par_n;
   logic              txd_n;
   logic              busy_n;

   logic              en_s;
   logic              en_prev;
   logic              armed;
   logic              trigger_c;
   logic              start_c;
   logic              last_stop_c;
   logic              clear_c;
   logic              bit_tick;

   // Bit-period timing; held at 0 in IDLE and restarted at every frame start.
   uart_baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_c),
      .bit_tick (bit_tick)
   );

   // Rising edge of the sampled en_start. armed stays low until en_start has
   // been seen low after reset, so a request held across reset is ignored.
   assign trigger_c = armed & en_s & ~en_prev;

   // Frame completion is a decode of registered state and the registered tick.
   assign frame_done = last_stop_c;

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state;
      shift_n     = shift_q;
      idx_n       = idx_q;
      par_n       = par_q;
      txd_n       = txd;
      start_c     = 1'b0;
      last_stop_c = (state == STOP) && bit_tick &&
                    (idx_q == IDX_W'(STOP_BITS - 1));

      case (state)
         IDLE: begin
            txd_n = 1'b1;
            if (mode ? trigger_c : 1'b1) begin
               start_c = 1'b1;
            end
         end

         START: begin
            if (bit_tick) begin
               state_n = DATA;
               txd_n   = shift_q[0];
               shift_n = shift_q >> 1;
               idx_n   = '0;
            end
         end

         DATA: begin
            if (bit_tick) begin
               if (idx_q == IDX_W'(DATA_W - 1)) begin
                  idx_n = '0;
                  if (PARITY != PAR_NONE) begin
                     state_n = PAR;
                     txd_n   = par_q;
                  end else begin
                     state_n = STOP;
                     txd_n   = 1'b1;
                  end
               end else begin
                  idx_n   = idx_q + IDX_W'(1);
                  txd_n   = shift_q[0];
                  shift_n = shift_q >> 1;
               end
            end
         end

         PAR: begin
            if (bit_tick) begin
               state_n = STOP;
               txd_n   = 1'b1;
               idx_n   = '0;
            end
         end

         STOP: begin
            if (bit_tick) begin
               if (last_stop_c) begin
                  // mode is only consulted here and in IDLE.
                  if (!mode) begin
                     start_c = 1'b1;
                  end else begin
                     state_n = IDLE;
                     txd_n   = 1'b1;
                     idx_n   = '0;
                  end
               end else begin
                  idx_n = idx_q + IDX_W'(1);
               end
            end
         end

         default: begin
            state_n = IDLE;
            txd_n   = 1'b1;
            idx_n   = '0;
         end
      endcase

      // Frame launch: latch payload and its parity, drive the start bit.
      if (start_c) begin
         state_n = START;
         txd_n   = 1'b0;
         shift_n = din;
         par_n   = parity_bit(MAX_DATA_W'(din), PARITY);
         idx_n   = '0;
      end

      busy_n  = (state_n != IDLE);
      clear_c = (state == IDLE) | start_c;
   end

   // State, output and request-history registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
         txd     <= 1'b1;
         busy    <= 1'b0;
         en_s    <= 1'b0;
         en_prev <= 1'b0;
         armed   <= 1'b0;
      end else begin
         state   <= state_n;
         shift_q <= shift_n;
         idx_q   <= idx_n;
         par_q   <= par_n;
         txd     <= txd_n;
         busy    <= busy_n;
         en_s    <= en_start;
         en_prev <= en_s;
         armed   <= armed | ~en_start;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
// Directed bench for uart_tx_cfg at CLK_DIV=4 with four configurations:
//   a: DATA_W=7 no parity, 1 stop    b: DATA_W=8 even parity
//   c: DATA_W=8 odd parity           d: DATA_W=7 no parity, 2 stop
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

   localparam int unsigned DIV = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst_v;
   logic [3:0] mode_v;
   logic [3:0] en_v;
   logic [6:0] din_a;
   logic [7:0] din_b;
   logic [7:0] din_c;
   logic [6:0] din_d;

   logic txd_a, txd_b, txd_c, txd_d;
   logic busy_a, busy_b, busy_c, busy_d;
   logic fd_a, fd_b, fd_c, fd_d;
   logic [3:0] txd_v, busy_v, fd_v;

   assign txd_v  = {txd_d, txd_c, txd_b, txd_a};
   assign busy_v = {busy_d, busy_c, busy_b, busy_a};
   assign fd_v   = {fd_d, fd_c, fd_b, fd_a};

   int checks = 0;
   int passed = 0;

   uart_tx_cfg #(.DATA_W(7), .CLK_DIV(DIV), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst_v[0]), .mode(mode_v[0]), .en_start(en_v[0]),
      .din(din_a), .txd(txd_a), .busy(busy_a), .frame_done(fd_a));

   uart_tx_cfg #(.DATA_W(8), .CLK_DIV(DIV), .PARITY(2), .STOP_BITS(1)) u_b (
      .clk(clk), .rst(rst_v[1]), .mode(mode_v[1]), .en_start(en_v[1]),
      .din(din_b), .txd(txd_b), .busy(busy_b), .frame_done(fd_b));

   uart_tx_cfg #(.DATA_W(8), .CLK_DIV(DIV), .PARITY(1), .STOP_BITS(1)) u_c (
      .clk(clk), .rst(rst_v[2]), .mode(mode_v[2]), .en_start(en_v[2]),
      .din(din_c), .txd(txd_c), .busy(busy_c), .frame_done(fd_c));

   uart_tx_cfg #(.DATA_W(7), .CLK_DIV(DIV), .PARITY(0), .STOP_BITS(2)) u_d (
      .clk(clk), .rst(rst_v[3]), .mode(mode_v[3]), .en_start(en_v[3]),
      .din(din_d), .txd(txd_d), .busy(busy_d), .frame_done(fd_d));

   // Records one frame from instance idx, starting at the first negedge where
   // txd is low (bounded by max_wait). Returns one sample per bit period.
   task automatic capture(input int idx, input int nbits, input int max_wait,
                          output logic [15:0] bits, output int waited,
                          output int busy_cnt, output int done_cnt,
                          output int done_pos, output bit unstable,
                          output bit timeout);
      bits     = '1;
      waited   = 0;
      busy_cnt = 0;
      done_cnt = 0;
      done_pos = -1;
      unstable = 1'b0;
      timeout  = 1'b0;
      while (txd_v[idx] !== 1'b0) begin
         if (waited >= max_wait) begin
            timeout = 1'b1;
            return;
         end
         @(negedge clk);
         waited++;
      end
      for (int c = 0; c < nbits * int'(DIV); c++) begin
         if (c % int'(DIV) == 0) bits[c / int'(DIV)] = txd_v[idx];
         else if (txd_v[idx] !== bits[c / int'(DIV)]) unstable = 1'b1;
         if (busy_v[idx] === 1'b1) busy_cnt++;
         if (fd_v[idx] === 1'b1) begin
            done_cnt++;
            done_pos = c;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_v  = 4'hF;
      mode_v = 4'hF;
      en_v   = 4'h0;
      din_a  = '0;
      din_b  = '0;
      din_c  = '0;
      din_d  = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (txd_v !== 4'hF) $display("FAIL reset_txd: got %b want 1111", txd_v);
      else passed++;
      checks++;
      if (busy_v !== 4'h0) $display("FAIL reset_busy: got %b want 0000", busy_v);
      else passed++;
      checks++;
      if (fd_v !== 4'h0) $display("FAIL reset_frame_done: got %b want 0000", fd_v);
      else passed++;
      rst_v = 4'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (txd_v !== 4'hF || busy_v !== 4'h0)
         $display("FAIL idle_after_reset: txd=%b busy=%b want 1111/0000", txd_v, busy_v);
      else passed++;
   endtask

   task automatic test_single_frame();
      logic [15:0] bits, expv;
      int waited, bcnt, dcnt, dpos;
      bit unst, tmo;
      expv      = 16'hFFFF;
      expv[8:0] = 9'b1_1010_1010;
      din_a   = 7'b1010101;
      en_v[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0)
         $display("FAIL trigger_latency: txd=%b busy=%b one edge after sample, want 1/0",
                  txd_v[0], busy_v[0]);
      else passed++;
      en_v[0] = 1'b0;
      @(negedge clk);
      capture(0, 9, 0, bits, waited, bcnt, dcnt, dpos, unst, tmo);
      checks++;
      if (tmo !== 1'b0 || waited != 0)
         $display("FAIL single_start_edge: timeout=%0d waited=%0d want 0/0", tmo, waited);
      else passed++;
      checks++;
      if (bits !== expv) $display("FAIL single_bits: got %b want %b", bits[8:0], expv[8:0]);
      else passed++;
      checks++;
      if (unst !== 1'b0) $display("FAIL single_bit_width: txd changed inside a bit period");
      else passed++;
      checks++;
      if (bcnt != 36) $display("FAIL single_busy_len: got %0d want 36", bcnt);
      else passed++;
      checks++;
      if (dcnt != 1 || dpos != 35)
         $display("FAIL single_frame_done: count=%0d pos=%0d want 1/35", dcnt, dpos);
      else passed++;
      checks++;
      if (busy_v[0] !== 1'b0 || txd_v[0] !== 1'b1)
         $display("FAIL single_return_idle: busy=%b txd=%b want 0/1", busy_v[0], txd_v[0]);
      else passed++;
   endtask

   task automatic test_parity();
      logic [15:0] bits, expv;
      int waited, bcnt, dcnt, dpos;
      bit unst, tmo;
      // Even parity, 0x55 has four ones -> parity bit 0.
      din_b      = 8'h55;
      expv       = 16'hFFFF;
      expv[10:0] = 11'b100_1010_1010;
      en_v[1] = 1'b1;
      @(negedge clk);
      en_v[1] = 1'b0;
      capture(1, 11, 8, bits, waited, bcnt, dcnt, dpos, unst, tmo);
      checks++;
      if (tmo !== 1'b0 || bits !== expv)
         $display("FAIL even_parity_frame: got %b want %b timeout=%0d", bits[10:0], expv[10:0], tmo);
      else passed++;
      checks++;
      if (bits[9] !== 1'b0) $display("FAIL even_parity_bit: got %b want 0", bits[9]);
      else passed++;
      checks++;
      if (bcnt != 44 || dcnt != 1)
         $display("FAIL even_parity_len: busy=%0d done=%0d want 44/1", bcnt, dcnt);
      else passed++;
      // Odd parity, same payload -> parity bit 1.
      din_c      = 8'h55;
      expv[10:0] = 11'b110_1010_1010;
      en_v[2] = 1'b1;
      @(negedge clk);
      en_v[2] = 1'b0;
      capture(2, 11, 8, bits, waited, bcnt, dcnt, dpos, unst, tmo);
      checks++;
      if (tmo !== 1'b0 || bits !== expv)
         $display("FAIL odd_parity_frame: got %b want %b timeout=%0d", bits[10:0], expv[10:0], tmo);
      else passed++;
      checks++;
      if (bits[9] !== 1'b1) $display("FAIL odd_parity_bit: got %b want 1", bits[9]);
      else passed++;
   endtask

   task automatic test_hold_high();
      int rises, dones;
      logic prev_busy;
      rises     = 0;
      dones     = 0;
      prev_busy = busy_v[0];
      en_v[0]   = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (busy_v[0] === 1'b1 && prev_busy !== 1'b1) rises++;
         if (fd_v[0] === 1'b1) dones++;
         prev_busy = busy_v[0];
      end
      en_v[0] = 1'b0;
      checks++;
      if (rises != 1) $display("FAIL hold_frames: got %0d frames want 1", rises);
      else passed++;
      checks++;
      if (dones != 1) $display("FAIL hold_frame_done: got %0d pulses want 1", dones);
      else passed++;
      checks++;
      if (busy_v[0] !== 1'b0) $display("FAIL hold_end_idle: busy=%b want 0", busy_v[0]);
      else passed++;
   endtask

   task automatic test_continuous();
      logic        tx_log [0:107];
      logic        fd_log [0:107];
      logic [15:0] obs, expv0, expv1;
      int idle_cycles, fd_errs, fd_cnt, later_busy;
      expv0      = 16'hFFFF;
      expv0[8:0] = 9'b1_0101_0100;
      expv1      = 16'hFFFF;
      expv1[8:0] = 9'b1_1100_1100;
      idle_cycles = 0;
      fd_errs     = 0;
      fd_cnt      = 0;
      din_a     = 7'b0101010;
      mode_v[0] = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 108; c++) begin
         tx_log[c] = txd_v[0];
         fd_log[c] = fd_v[0];
         if (busy_v[0] !== 1'b1) idle_cycles++;
         if (fd_v[0] === 1'b1) fd_cnt++;
         if ((fd_v[0] === 1'b1) != ((c % 36) == 35)) fd_errs++;
         if (c == 10) din_a = 7'b1100110;
         if (c == 80) mode_v[0] = 1'b1;
         @(negedge clk);
      end
      for (int f = 0; f < 3; f++) begin
         obs = 16'hFFFF;
         for (int k = 0; k < 9; k++) obs[k] = tx_log[f * 36 + k * int'(DIV) + 2];
         checks++;
         if (obs !== ((f == 0) ? expv0 : expv1))
            $display("FAIL cont_frame%0d_bits: got %b want %b", f, obs[8:0],
                     (f == 0) ? expv0[8:0] : expv1[8:0]);
         else passed++;
      end
      checks++;
      if (idle_cycles != 0 || tx_log[36] !== 1'b0 || tx_log[72] !== 1'b0)
         $display("FAIL cont_no_gap: idle=%0d start36=%b start72=%b want 0/0/0",
                  idle_cycles, tx_log[36], tx_log[72]);
      else passed++;
      checks++;
      if (fd_cnt != 3 || fd_errs != 0 || fd_log[107] !== 1'b1)
         $display("FAIL cont_frame_done: count=%0d misplaced=%0d want 3/0", fd_cnt, fd_errs);
      else passed++;
      later_busy = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy_v[0] !== 1'b0 || txd_v[0] !== 1'b1) later_busy++;
         @(negedge clk);
      end
      checks++;
      if (later_busy != 0)
         $display("FAIL mode_switch_idle: %0d non-idle cycles after switch, want 0", later_busy);
      else passed++;
   endtask

   task automatic test_reset_abort();
      logic [15:0] bits, expv;
      int waited, bcnt, dcnt, dpos, fd_seen, busy_seen;
      bit unst, tmo;
      expv      = 16'hFFFF;
      expv[9:0] = 10'b11_0011_0110;
      fd_seen   = 0;
      busy_seen = 0;
      waited    = 0;
      din_d   = 7'b0011011;
      en_v[3] = 1'b1;
      @(negedge clk);
      en_v[3] = 1'b0;
      while (txd_v[3] !== 1'b0 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (txd_v[3] !== 1'b0) $display("FAIL abort_start: txd=%b want 0 within 8 cycles", txd_v[3]);
      else passed++;
      repeat (15) @(negedge clk);
      checks++;
      if (txd_v[3] !== 1'b0) $display("FAIL abort_cycle15_bit: txd=%b want 0", txd_v[3]);
      else passed++;
      rst_v[3] = 1'b1;
      en_v[3]  = 1'b1;
      #1;
      checks++;
      if (txd_v[3] !== 1'b1 || busy_v[3] !== 1'b0 || fd_v[3] !== 1'b0)
         $display("FAIL abort_async: txd=%b busy=%b done=%b want 1/0/0",
                  txd_v[3], busy_v[3], fd_v[3]);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (fd_v[3] === 1'b1) fd_seen++;
         if (busy_v[3] === 1'b1 || txd_v[3] !== 1'b1) busy_seen++;
      end
      rst_v[3] = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (fd_v[3] === 1'b1) fd_seen++;
         if (busy_v[3] === 1'b1 || txd_v[3] !== 1'b1) busy_seen++;
      end
      checks++;
      if (fd_seen != 0 || busy_seen != 0)
         $display("FAIL abort_no_frame: done=%0d active=%0d want 0/0", fd_seen, busy_seen);
      else passed++;
      en_v[3] = 1'b0;
      repeat (2) @(negedge clk);
      en_v[3] = 1'b1;
      @(negedge clk);
      en_v[3] = 1'b0;
      capture(3, 10, 8, bits, waited, bcnt, dcnt, dpos, unst, tmo);
      checks++;
      if (tmo !== 1'b0 || bits !== expv)
         $display("FAIL two_stop_bits: got %b want %b timeout=%0d", bits[9:0], expv[9:0], tmo);
      else passed++;
      checks++;
      if (bcnt != 40 || dcnt != 1 || dpos != 39)
         $display("FAIL two_stop_len: busy=%0d done=%0d pos=%0d want 40/1/39", bcnt, dcnt, dpos);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_parity();
      test_hold_high();
      test_continuous();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, passed=%0d checks=%0d", passed, checks);
      $fatal(1);
   end

endmodule
